arbiter_4ch: RTL and testbench
==============================

ARBITER_4CH -- requirements
Module: arbiter_4ch

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, the maximum number of consecutive cycles one requester may hold a grant (legal range 2..256).
REQ-002 The block SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port req  input  4  request lines, bit i = requester i.
REQ-005 The block SHALL have port done  input  1  current owner releases the resource this cycle.
REQ-006 The block SHALL have port grant  output  4  one-hot grant, the 2-to-4 decode of grant_idx while busy, else 4'b0000.
REQ-007 The block SHALL have port grant_idx  output  2  index of current or most recent owner.
REQ-008 The block SHALL have port busy  output  1  high while a grant is active.
REQ-009 The block SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-010 The block SHALL implement a two-state FSM: IDLE (no grant) and GRANT (grant active).
REQ-011 In IDLE with req != 0 at edge N, the block SHALL enter GRANT, so grant, busy and grant_idx are valid from cycle N+1 (one-cycle latency).
REQ-012 In IDLE with req == 0, the block SHALL remain in IDLE with grant = 0, busy = 0, and grant_idx holding its last value.
REQ-013 Selection SHALL be round-robin: search starts at index ptr and wraps 3 -> 0; the first asserted req bit wins.
REQ-014 On every grant, ptr SHALL become (winner + 1) mod 4; ptr SHALL be unchanged otherwise.
REQ-015 grant SHALL be one-hot or zero in every cycle; two bits SHALL never be set together.
REQ-016 In GRANT, a hold counter SHALL start at 0 on grant entry and increment by 1 per cycle the FSM stays in GRANT.
REQ-017 GRANT SHALL exit to IDLE at the next edge when done = 1, or when req[grant_idx] = 0 (owner withdrew).
REQ-018 GRANT SHALL exit to IDLE at the next edge when the hold counter equals MAX_HOLD-1, and timeout SHALL be high for exactly the first IDLE cycle.
REQ-019 If done (or owner withdrawal) and the hold limit occur in the same cycle, release SHALL take priority and timeout SHALL stay 0.
REQ-020 After any GRANT exit, the block SHALL spend at least one cycle in IDLE with grant = 0 (dead cycle) before a new grant.
REQ-021 done asserted while in IDLE SHALL be ignored.
REQ-022 A requester's req changes while another requester owns the grant SHALL not affect the current grant.
REQ-023 The hold counter SHALL be wide enough for MAX_HOLD-1 and SHALL never wrap during a grant.

Reset
REQ-024 While reset = 0 at a rising edge, the block SHALL set state = IDLE, ptr = 0, hold counter = 0, grant_idx = 0, grant = 4'b0000, busy = 0, timeout = 0.
REQ-025 Reset SHALL override everything, including an active grant; the grant SHALL drop at the first edge with reset = 0.
REQ-026 After reset deasserts, the first arbitration SHALL start searching at index 0.

Verification
REQ-027 Reset, then req = 4'b1111 held with done pulsed one cycle after each grant: grant sequence SHALL be 0001, 0010, 0100, 1000, 0001, with one zero-grant cycle between grants.
REQ-028 req = 4'b0100 for one cycle from IDLE: grant = 0100 and grant_idx = 2 next cycle; then req = 0 SHALL give grant = 0 the following cycle, with timeout = 0.
REQ-029 MAX_HOLD = 4, req = 4'b0001 held, done = 0: grant SHALL stay high 4 cycles, then IDLE with timeout = 1 for one cycle, then a re-grant to 0001.
REQ-030 MAX_HOLD = 4, done = 1 in the 4th grant cycle: IDLE SHALL follow with timeout = 0.
REQ-031 reset = 0 asserted mid-grant with grant = 1000: grant SHALL be 0000 and grant_idx = 0 next cycle; with req = 4'b1001 after release, the first grant SHALL be 0001.
REQ-032 All scenarios: a checker SHALL flag any cycle where grant has more than one bit set, or grant != 0 while busy = 0.

Source files
------------

// File: rtl/arbiter_4ch_if.sv
// arbiter_4ch_if -- request/grant bundle between four requesters and arbiter_4ch.
//
// Signals:
//   req[3:0]       requester -> arbiter, bit i = requester i wants the resource
//   done           owner -> arbiter, the current owner releases the resource
//   grant[3:0]     arbiter -> requesters, one-hot owner, zero when idle
//   grant_idx[1:0] arbiter -> requesters, index of current or most recent owner
//   busy           arbiter -> requesters, a grant is active
//   timeout        arbiter -> requesters, one-cycle pulse after a hold-limit revoke
//   dbg_state      arbiter -> observers, FSM state (0 = IDLE, 1 = GRANT)
//
// Handshake: a requester raises req[i] and holds it until it sees grant[i]; it
// owns the resource for every cycle grant[i] is high. The owner ends ownership
// by pulsing done or by dropping req[i]; the arbiter may also revoke the grant
// at the hold limit, in which case timeout pulses. Every grant is followed by
// at least one cycle with grant == 0 before the next grant.
interface arbiter_4ch_if;
   logic [3:0] req;
   logic       done;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       busy;
   logic       timeout;
   logic       dbg_state;

   modport master (
      output req, done,
      input  grant, grant_idx, busy, timeout, dbg_state
   );

   modport slave (
      input  req, done,
      output grant, grant_idx, busy, timeout, dbg_state
   );
endinterface

// File: rtl/arbiter_4ch.sv
// arbiter_4ch -- four-requester round-robin arbiter with a hold limit.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-low reset
//   arb_io  arbiter_4ch_if.slave: req/done in; grant/grant_idx/busy/timeout/dbg_state out
//
// Parameter:
//   MAX_HOLD  maximum consecutive grant cycles for one owner (2..256)
//
// A grant is issued one cycle after a request is seen in IDLE. The round-robin
// pointer moves past each winner so every requester is reached within four
// grants. An owner leaves by done or by dropping its request; otherwise the
// grant is revoked after MAX_HOLD cycles and timeout pulses once.
module arbiter_4ch #(
   parameter int MAX_HOLD = 8
) (
   input  logic          clk,
   input  logic          reset,
   arbiter_4ch_if.slave  arb_io
);

   // Counter only needs to reach MAX_HOLD-1, so clog2(MAX_HOLD) bits suffice.
   localparam int CW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] hold_q, hold_d;
   logic          timeout_q, timeout_d;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 2'd0;
         idx_q     <= 2'd0;
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         idx_q     <= idx_d;
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state logic
   always_comb begin
      logic       win_found;
      logic [1:0] win_idx;
      logic [1:0] cand;
      logic       release_now;

      state_d   = state_q;
      ptr_d     = ptr_q;
      idx_d     = idx_q;
      hold_d    = hold_q;
      timeout_d = 1'b0;

      // Round-robin search starting at ptr; the 2-bit add wraps 3 -> 0.
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = ptr_q;
      for (int k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!win_found && arb_io.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end

      release_now = arb_io.done || !arb_io.req[idx_q];

      case (state_q)
         ST_IDLE: begin
            // done is meaningless without an owner and is ignored here.
            if (win_found) begin
               state_d = ST_GRANT;
               idx_d   = win_idx;
               ptr_d   = win_idx + 2'd1;
               hold_d  = '0;
            end
         end
         ST_GRANT: begin
            // A voluntary release wins over a simultaneous hold-limit revoke.
            if (release_now) begin
               state_d = ST_IDLE;
            end else if (hold_q == HOLD_LAST) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               hold_d = hold_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      arb_io.busy      = (state_q == ST_GRANT);
      arb_io.grant     = (state_q == ST_GRANT) ? (4'b0001 << idx_q) : 4'b0000;
      arb_io.grant_idx = idx_q;
      arb_io.timeout   = timeout_q;
      arb_io.dbg_state = state_q;
   end

endmodule

// File: tb/tb_arbiter_4ch.sv
// tb_arbiter_4ch -- directed bench for arbiter_4ch with MAX_HOLD = 4.
// Inputs change 1 ns after a rising edge; outputs are checked at that point,
// reflecting the edge just taken. A negedge monitor checks grant legality.
module tb_arbiter_4ch;

   localparam int HOLD = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   logic mon_en;
   logic [3:0] exp_q[$];

   arbiter_4ch_if arb_bus ();

   arbiter_4ch #(.MAX_HOLD(HOLD)) dut (
      .clk    (clk),
      .reset  (reset),
      .arb_io (arb_bus)
   );

   // Clock / watchdog
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // Checking
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] g, input logic b,
                          input logic [1:0] idx, input logic to);
      chk({tag, ".grant"},     32'(arb_bus.grant),     32'(g));
      chk({tag, ".busy"},      32'(arb_bus.busy),      32'(b));
      chk({tag, ".grant_idx"}, 32'(arb_bus.grant_idx), 32'(idx));
      chk({tag, ".timeout"},   32'(arb_bus.timeout),   32'(to));
   endtask

   // Grant must be one-hot or zero, and zero whenever busy is low.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("grant_legal",
             32'(($countones(arb_bus.grant) <= 1) && (arb_bus.busy || arb_bus.grant == 4'b0000)),
             32'd1);
      end
   end

   // Driver
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] g;
      logic [1:0] gi;
      n_checks = 0;
      n_errors = 0;
      mon_en   = 1'b0;
      reset    = 1'b0;
      arb_bus.req  = 4'b1111;
      arb_bus.done = 1'b0;

      // Reset with requests pending: nothing may be granted.
      step();
      step();
      mon_en = 1'b1;
      chk_out("reset", 4'b0000, 1'b0, 2'd0, 1'b0);
      chk("reset.state", 32'(arb_bus.dbg_state), 32'd0);

      // Round robin over all four, done in the first grant cycle.
      exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      reset = 1'b1;
      while (exp_q.size() > 0) begin
         g  = exp_q.pop_front();
         gi = (g == 4'b0001) ? 2'd0 : (g == 4'b0010) ? 2'd1 : (g == 4'b0100) ? 2'd2 : 2'd3;
         step();
         chk_out("rr_grant", g, 1'b1, gi, 1'b0);
         chk("rr_state", 32'(arb_bus.dbg_state), 32'd1);
         arb_bus.done = 1'b1;
         step();
         chk_out("rr_dead", 4'b0000, 1'b0, gi, 1'b0);
         arb_bus.done = 1'b0;
      end
      // ptr = 1 now.

      // Single-cycle request from IDLE, then withdrawal.
      arb_bus.req = 4'b0100;
      step();
      chk_out("wd_grant", 4'b0100, 1'b1, 2'd2, 1'b0);
      arb_bus.req = 4'b0000;
      step();
      chk_out("wd_rel", 4'b0000, 1'b0, 2'd2, 1'b0);
      step();
      chk_out("idle_hold_idx", 4'b0000, 1'b0, 2'd2, 1'b0);
      // done in IDLE is ignored. ptr = 3.
      arb_bus.done = 1'b1;
      step();
      chk_out("idle_done", 4'b0000, 1'b0, 2'd2, 1'b0);
      arb_bus.done = 1'b0;

      // Hold limit: 4 grant cycles, timeout pulse, re-grant. Search 3 -> 0.
      arb_bus.req = 4'b0001;
      for (int c = 0; c < HOLD; c++) begin
         step();
         chk_out("hold_grant", 4'b0001, 1'b1, 2'd0, 1'b0);
      end
      step();
      chk_out("hold_timeout", 4'b0000, 1'b0, 2'd0, 1'b1);
      step();
      chk_out("hold_regrant", 4'b0001, 1'b1, 2'd0, 1'b0);

      // done in the 4th grant cycle beats the hold limit.
      for (int c = 1; c < HOLD; c++) begin
         step();
         chk_out("hold_grant2", 4'b0001, 1'b1, 2'd0, 1'b0);
      end
      arb_bus.done = 1'b1;
      step();
      chk_out("done_vs_limit", 4'b0000, 1'b0, 2'd0, 1'b0);
      arb_bus.done = 1'b0;
      arb_bus.req  = 4'b0000;
      step();
      chk_out("after_limit", 4'b0000, 1'b0, 2'd0, 1'b0);
      // ptr = 1.

      // Other requesters changing must not disturb the owner.
      arb_bus.req = 4'b0010;
      step();
      chk_out("steady_grant", 4'b0010, 1'b1, 2'd1, 1'b0);
      arb_bus.req = 4'b1011;
      step();
      chk_out("steady_1011", 4'b0010, 1'b1, 2'd1, 1'b0);
      arb_bus.req = 4'b0110;
      step();
      chk_out("steady_0110", 4'b0010, 1'b1, 2'd1, 1'b0);
      arb_bus.done = 1'b1;
      arb_bus.req  = 4'b0000;
      step();
      chk_out("steady_rel", 4'b0000, 1'b0, 2'd1, 1'b0);
      arb_bus.done = 1'b0;
      // ptr = 2: with 1001 the search 2,3 picks requester 3.
      arb_bus.req = 4'b1001;
      step();
      chk_out("rr_skip", 4'b1000, 1'b1, 2'd3, 1'b0);
      step();
      chk_out("rr_skip_hold", 4'b1000, 1'b1, 2'd3, 1'b0);

      // Reset mid-grant drops the grant and restarts the search at 0.
      reset = 1'b0;
      step();
      chk_out("mid_reset", 4'b0000, 1'b0, 2'd0, 1'b0);
      reset = 1'b1;
      step();
      chk_out("post_reset", 4'b0001, 1'b1, 2'd0, 1'b0);
      arb_bus.done = 1'b1;
      arb_bus.req  = 4'b0000;
      step();
      chk_out("final_rel", 4'b0000, 1'b0, 2'd0, 1'b0);
      arb_bus.done = 1'b0;
      step();

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
